cmp_issue_arbiter: RTL

- Shared branch-compare functional unit for the out-of-order core.
- Arbitrates round-robin among NUM_RS branch reservation-station entries and captures the winner's operands, funct3 and ROB tag into an issue register.
- Drives the existing combinational branch comparator (instantiated inside), registers br_en with its tag, and presents it to the CDB with a valid/ready handshake.
- Two-stage pipeline (issue register -> result register) with full back-pressure and flush.

---
 rtl/cmp_issue_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cmp_issue_arbiter.sv
// Shared branch-compare unit: round-robin issue arbiter, issue register,
// combinational branch comparator and a result register feeding the CDB.
//
// Handshakes: every transfer uses strict valid/ready semantics. A beat moves
// on a rising edge exactly when valid and ready are both high. Valid never
// waits on ready. A producer holding valid keeps its payload stable until the
// beat is taken. On the request side, req_ready is a one-hot grant. On the
// CDB side, out_valid/out_br_en/out_tag hold while out_ready is low.

// Combinational RV32I branch comparator keyed by funct3.
module cmp_branch_comparator (
  input  logic [2:0]  cmpop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        br_en
);

  // Decode funct3; the reserved encodings 010/011 never take the branch.
  always_comb begin
    br_en = 1'b0;
    case (cmpop)
      3'b000:  br_en = (a == b);
      3'b001:  br_en = (a != b);
      3'b100:  br_en = ($signed(a) <  $signed(b));
      3'b101:  br_en = ($signed(a) >= $signed(b));
      3'b110:  br_en = (a <  b);
      3'b111:  br_en = (a >= b);
      default: br_en = 1'b0;
    endcase
  end

endmodule

module cmp_issue_arbiter #(
  parameter int NUM_RS = 4,
  parameter int TAG_W  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_RS-1:0]              req_valid,
  input  logic [NUM_RS-1:0][31:0]        req_rs1,
  input  logic [NUM_RS-1:0][31:0]        req_rs2,
  input  logic [NUM_RS-1:0][2:0]         req_cmpop,
  input  logic [NUM_RS-1:0][TAG_W-1:0]   req_tag,
  output logic [NUM_RS-1:0]              req_ready,
  output logic                           out_valid,
  output logic                           out_br_en,
  output logic [TAG_W-1:0]               out_tag,
  input  logic                           out_ready
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  // Issue register.
  logic              iv;
  logic [31:0]       iss_rs1;
  logic [31:0]       iss_rs2;
  logic [2:0]        iss_cmpop;
  logic [TAG_W-1:0]  iss_tag;

  // Round-robin pointer: the entry scanned first.
  logic [PTR_W-1:0]  ptr;

  logic              res_free;
  logic              iss_adv;
  logic              iss_free;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W:0]    scan_idx;
  logic [PTR_W-1:0]  ptr_next;
  logic              br_en;

  // A stage is free when it is empty or its content moves on this edge.
  assign res_free = !out_valid || out_ready;
  assign iss_adv  = iv && res_free;
  assign iss_free = !iv || iss_adv;

  // Rotating-priority scan starting at ptr, wrapping modulo NUM_RS.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    req_ready = '0;
    if (iss_free && !flush && !rst) begin
      for (int j = 0; j < NUM_RS; j++) begin
        scan_idx = {1'b0, ptr} + (PTR_W+1)'(j);
        if (scan_idx >= (PTR_W+1)'(NUM_RS)) begin
          scan_idx = scan_idx - (PTR_W+1)'(NUM_RS);
        end
        if (!grant_any && req_valid[scan_idx[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx[PTR_W-1:0];
        end
      end
    end
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Entry after the winner, wrapping for non-power-of-two NUM_RS.
  assign ptr_next = (grant_idx == PTR_W'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;

  cmp_branch_comparator u_cmp (
    .cmpop (iss_cmpop),
    .a     (iss_rs1),
    .b     (iss_rs2),
    .br_en (br_en)
  );

  // Issue register and pointer: refill on grant, drain on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      iv        <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_cmpop <= '0;
      iss_tag   <= '0;
      ptr       <= '0;
    end else if (flush) begin
      iv <= 1'b0;
    end else if (grant_any) begin
      iv        <= 1'b1;
      iss_rs1   <= req_rs1[grant_idx];
      iss_rs2   <= req_rs2[grant_idx];
      iss_cmpop <= req_cmpop[grant_idx];
      iss_tag   <= req_tag[grant_idx];
      ptr       <= ptr_next;
    end else if (iss_adv) begin
      iv <= 1'b0;
    end
  end

  // Result register: load on issue advance, clear once the CDB takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_br_en <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (iss_adv) begin
      out_valid <= 1'b1;
      out_br_en <= br_en;
      out_tag   <= iss_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
